// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with valid/ready handshakes on both sides.
//
// Storage is an inferred RAM with a synchronous read port, followed by a
// registered output stage. Total capacity is DEPTH+1 words: DEPTH RAM
// entries plus the output register.
//
// Optional feature macro: SYNC_FIFO_FLUSH_EN
//   When defined, adds the flush input. flush clears the FIFO state
//   synchronously, like reset. flush is overridden by reset and takes
//   priority over any transfer at the same edge.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-low reset
//   flush            synchronous clear (only with SYNC_FIFO_FLUSH_EN)
//   in_valid         producer presents in_data
//   in_ready         FIFO accepts a word this cycle (registered state only)
//   in_data          write data
//   in_almost_full   level >= ALMOST_FULL_LEVEL (registered)
//   out_valid        out_data holds a valid word
//   out_ready        consumer takes out_data this cycle
//   out_data         registered read data
//   out_almost_empty level <= ALMOST_EMPTY_LEVEL (registered)
//   level            words held: RAM entries plus output register
module sync_fifo #(
  parameter int WIDTH              = 8,
  parameter int DEPTH              = 512,
  parameter int ALMOST_FULL_LEVEL  = DEPTH,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef SYNC_FIFO_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_almost_full,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_almost_empty,
  output logic [$clog2(DEPTH+2)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+2);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(ALMOST_FULL_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(ALMOST_EMPTY_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    ram_count_q, ram_count_d;
  logic [LW-1:0]    level_d;
  logic             out_valid_q, out_valid_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic [WIDTH-1:0] out_data_q;

  logic clear;
  logic wr_fire;
  logic rd_fire;
  logic load;

`ifdef SYNC_FIFO_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // in_ready depends only on registered state, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready = (ram_count_q != DEPTH_L);

  // A flush discards any transfer at the same edge.
  assign wr_fire = in_valid && in_ready && !clear;
  assign rd_fire = out_valid_q && out_ready;

  // Refill the output register when it is empty or being drained, as long
  // as the RAM holds something. A word written this edge is not bypassed.
  assign load = (ram_count_q != '0) && (!out_valid_q || rd_fire) && !clear;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      out_valid_d = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (load) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_fire, load})
        2'b10:   ram_count_d = ram_count_q + LW'(1);
        2'b01:   ram_count_d = ram_count_q - LW'(1);
        default: ram_count_d = ram_count_q;
      endcase
      if (load) begin
        out_valid_d = 1'b1;
      end else if (rd_fire) begin
        out_valid_d = 1'b0;
      end
    end

    // Flags come from the next-state level so they line up with level.
    level_d        = ram_count_d + {{(LW-1){1'b0}}, out_valid_d};
    almost_full_d  = (level_d >= AF_L);
    almost_empty_d = (level_d <= AE_L);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ram_count_q    <= '0;
      out_valid_q    <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ram_count_q    <= ram_count_d;
      out_valid_q    <= out_valid_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // RAM write port. Contents are never cleared.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Synchronous RAM read straight into the output register. A load never
  // targets the entry being written: when the pointers are equal the RAM is
  // either empty (no load) or full (no write).
  always_ff @(posedge clock) begin
    if (load) begin
      out_data_q <= mem[rd_ptr_q];
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign in_almost_full   = almost_full_q;
  assign out_almost_empty = almost_empty_q;
  assign level            = ram_count_q + {{(LW-1){1'b0}}, out_valid_q};

endmodule

// File: tb/tb_sync_fifo.sv
`timescale 1ns/1ps
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AFL   = 7;
  localparam int AEL   = 1;
  localparam int LW    = $clog2(DEPTH+2);
  localparam int NSTREAM = 3*DEPTH + 5;

  logic             clock     = 1'b0;
  logic             reset     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
`ifdef SYNC_FIFO_FLUSH_EN
  logic             flush     = 1'b0;
`endif
  logic             in_ready;
  logic             in_almost_full;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_almost_empty;
  logic [LW-1:0]    level;

  sync_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH),
    .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) dut (
    .clock(clock),
    .reset(reset),
`ifdef SYNC_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_almost_full(in_almost_full),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_almost_empty(out_almost_empty),
    .level(level)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One vector: inputs applied at an edge, outputs expected just after it.
  typedef struct {
    logic       rst_n;
    logic       fl;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_dat;
    int         e_lvl;
    logic       e_af;
    logic       e_ae;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic fl, input logic iv,
                     input logic [7:0] din, input logic ordy,
                     input logic e_ir, input logic e_ov,
                     input logic [7:0] e_dat, input int e_lvl);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_dat = e_dat; v.e_lvl = e_lvl;
    v.e_af = (e_lvl >= AFL);
    v.e_ae = (e_lvl <= AEL);
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Behavioural model: queue of all held words, front is the output slot
  // when m_ov is set.
  logic [7:0] mq[$];
  bit         m_ov;

  initial begin
    int nxt;
    int acc;
    int expw;
    int sent;
    int recv;
    int m_ram;
    bit was_ready, wr, rd, ld;

    #100000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int nxt, acc, expw, sent, recv, m_ram, pr;
    bit was_ready, wr, rd, ld;

    // Reset, single word latency, level=5 then reset and restart.
    add(0,0,0,8'h00,0, 1,0,8'h00,0);
    add(0,0,0,8'h00,0, 1,0,8'h00,0);
    add(1,0,0,8'h00,0, 1,0,8'h00,0);
    add(1,0,1,8'hA5,1, 1,0,8'h00,1);
    add(1,0,0,8'h00,1, 1,1,8'hA5,1);
    add(1,0,0,8'h00,1, 1,0,8'h00,0);
    add(1,0,1,8'h10,0, 1,0,8'h00,1);
    add(1,0,1,8'h11,0, 1,1,8'h10,2);
    add(1,0,1,8'h12,0, 1,1,8'h10,3);
    add(1,0,1,8'h13,0, 1,1,8'h10,4);
    add(1,0,1,8'h14,0, 1,1,8'h10,5);
    add(0,0,1,8'h55,1, 1,0,8'h00,0);
    add(1,0,1,8'h3C,1, 1,0,8'h00,1);
    add(1,0,0,8'h00,0, 1,1,8'h3C,1);
    add(1,0,0,8'h00,1, 1,0,8'h00,0);
`ifdef SYNC_FIFO_FLUSH_EN
    add(1,0,1,8'h20,0, 1,0,8'h00,1);
    add(1,0,1,8'h21,0, 1,1,8'h20,2);
    add(1,0,1,8'h22,0, 1,1,8'h20,3);
    add(1,0,1,8'h23,0, 1,1,8'h20,4);
    add(1,0,1,8'h24,0, 1,1,8'h20,5);
    add(1,1,1,8'h77,1, 1,0,8'h00,0);
    add(1,0,1,8'h3C,1, 1,0,8'h00,1);
    add(1,0,0,8'h00,0, 1,1,8'h3C,1);
    add(1,0,0,8'h00,1, 1,0,8'h00,0);
`endif

    foreach (vecs[i]) begin
      reset     = vecs[i].rst_n;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].din;
      out_ready = vecs[i].ordy;
`ifdef SYNC_FIFO_FLUSH_EN
      flush     = vecs[i].fl;
`endif
      tick();
      chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
      chk($sformatf("v%0d_level", i), int'(level), vecs[i].e_lvl);
      chk($sformatf("v%0d_almost_full", i), int'(in_almost_full), int'(vecs[i].e_af));
      chk($sformatf("v%0d_almost_empty", i), int'(out_almost_empty), int'(vecs[i].e_ae));
      if (vecs[i].e_ov)
        chk($sformatf("v%0d_out_data", i), int'(out_data), int'(vecs[i].e_dat));
      $display("vec %0d: lvl=%0d ov=%0d data=%02h", i, level, out_valid, out_data);
    end
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
`ifdef SYNC_FIFO_FLUSH_EN
    flush = 1'b0;
`endif

    // Fill to capacity with the consumer stalled.
    nxt = 0; acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_data = nxt[7:0];
      chk($sformatf("s3_in_ready_c%0d", c), int'(in_ready), int'(c < 9));
      was_ready = in_ready;
      tick();
      if (was_ready) begin nxt++; acc++; end
      chk($sformatf("s3_level_c%0d", c), int'(level), (c + 1 < 9) ? c + 1 : 9);
      chk($sformatf("s3_af_c%0d", c), int'(in_almost_full), int'(((c + 1 < 9) ? c + 1 : 9) >= AFL));
      $display("fill %0d: lvl=%0d in_ready=%0d af=%0d", c, level, in_ready, in_almost_full);
    end
    chk("s3_accepted", acc, 9);
    chk("s3_full_in_ready", int'(in_ready), 0);
    chk("s3_full_level", int'(level), 9);

    // One read pulse while full: no same-cycle write.
    in_data = nxt[7:0];
    out_ready = 1'b1;
    chk("s4_head_valid", int'(out_valid), 1);
    chk("s4_head_data", int'(out_data), 8'h00);
    tick();
    out_ready = 1'b0;
    chk("s4_ready_after_pulse", int'(in_ready), 1);
    chk("s4_level_after_pulse", int'(level), 8);
    tick();
    $display("refill: lvl=%0d in_ready=%0d", level, in_ready);
    chk("s4_level_refill", int'(level), 9);
    chk("s4_ready_refill", int'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    expw = 1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        chk($sformatf("s4_drain_w%0d", expw), int'(out_data), expw);
        $display("drain: data=%02h", out_data);
        expw++;
      end
      tick();
    end
    chk("s4_drain_count", expw, 10);
    chk("s4_drain_level", int'(level), 0);
    out_ready = 1'b0;

    // Randomised stream against the behavioural model.
    reset = 1'b0; tick(); reset = 1'b1;
    mq.delete(); m_ov = 0; sent = 0; recv = 0;
    for (int c = 0; c < 3000 && recv < NSTREAM; c++) begin
      m_ram = mq.size() - int'(m_ov);
      chk("s5_in_ready", int'(in_ready), int'(m_ram != DEPTH));
      chk("s5_out_valid", int'(out_valid), int'(m_ov));
      chk("s5_level", int'(level), mq.size());
      chk("s5_af", int'(in_almost_full), int'(mq.size() >= AFL));
      chk("s5_ae", int'(out_almost_empty), int'(mq.size() <= AEL));
      chk("s5_level_bound", int'(level <= LW'(DEPTH + 1)), 1);
      if (m_ov) chk("s5_out_data", int'(out_data), int'(mq[0]));

      pr = (c < 40) ? 25 : 75;
      in_valid  = (sent < NSTREAM) && ($urandom_range(0, 99) < 60);
      in_data   = WIDTH'(32'h40 + sent);
      out_ready = ($urandom_range(0, 99) < pr);

      wr = in_valid && (m_ram != DEPTH);
      rd = m_ov && out_ready;
      ld = (m_ram > 0) && (!m_ov || rd);
      if (rd) begin
        chk($sformatf("s5_order_w%0d", recv), int'(out_data), 32'h40 + recv);
        $display("stream rx %0d: data=%02h lvl=%0d", recv, out_data, level);
        void'(mq.pop_front());
        recv++;
      end
      if (wr) begin
        mq.push_back(in_data);
        sent++;
      end
      if (ld) m_ov = 1;
      else if (rd) m_ov = 0;
      tick();
    end
    chk("s5_received", recv, NSTREAM);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parametrised FIFO with a valid/ready handshake on both sides, a registered output stage, an occupancy count and programmable almost-full/almost-empty thresholds.
- Next-generation buffer for intra-domain streams, e.g. UART/SPI byte queues and bus request buffering. It replaces ad-hoc dual-clock FIFOs wherever both sides share one clock.
- Storage is an inferred array with a synchronous read port, so it maps to block RAM.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 512, RAM storage entries; power of two, >=2
ALMOST_FULL_LEVEL, DEPTH, in_almost_full asserts when level >= this value; range 1..DEPTH+1
ALMOST_EMPTY_LEVEL, 1, out_almost_empty asserts when level <= this value; range 0..DEPTH

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  producer has a word on in_data
in_ready  output  1  FIFO can accept a word this cycle
in_data  input  WIDTH  write data
in_almost_full  output  1  level >= ALMOST_FULL_LEVEL
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  registered read data
out_almost_empty  output  1  level <= ALMOST_EMPTY_LEVEL
level  output  $clog2(DEPTH+2)  words held: RAM entries plus output register
flush  input  1  only with SYNC_FIFO_FLUSH_EN; see Optional Feature

Behaviour:
- Reset (reset==0 at an edge):
  - Write pointer, read pointer, RAM count and out_valid are cleared to 0.
  - After reset: in_ready=1, level=0, out_almost_empty=1, in_almost_full=0.
  - out_data is don't-care; RAM contents are not cleared.
  - Reset mid-operation discards all held words. The next word out is the first word written after reset.
- Handshake:
  - A write transfer occurs when in_valid && in_ready at an edge.
  - A read transfer occurs when out_valid && out_ready at an edge.
  - in_valid and out_ready may be held high indefinitely. in_data is ignored while in_ready==0.
- Input side:
  - in_ready = (ram_count != DEPTH), driven from registered state only. There is no combinational path from out_ready.
  - A write stores in_data at the write pointer and increments the pointer modulo DEPTH (natural wrap, $clog2(DEPTH) bits).
- Output stage:
  - The output register loads when ram_count != 0 and either out_valid==0 or a read transfer occurs this edge.
  - A load reads the RAM at the read pointer, increments the read pointer, decrements ram_count and sets out_valid.
  - If a read transfer occurs with ram_count==0, out_valid clears.
- Latency: a word written at edge N with an empty FIFO has out_valid=1 after edge N+1, i.e. 2 cycles from in_valid to out_valid.
- Throughput: one word per cycle sustained, with simultaneous write and read.
- Full behaviour:
  - Capacity is DEPTH+1 words (RAM plus output register).
  - When full, a read frees one RAM slot at that edge. in_ready rises the following cycle; there is no same-cycle pass-through.
- Empty behaviour:
  - out_ready is ignored while out_valid==0.
  - A simultaneous write into an empty RAM is not bypassed to out_data. It follows the 2-cycle latency.
- ram_count:
  - Incremented on write only, decremented on load only, unchanged when both happen at the same edge.
  - Never exceeds DEPTH or underflows.
- Flags and level:
  - level = ram_count + out_valid.
  - in_almost_full and out_almost_empty are registered and computed from the next-state level, so they are always consistent with level in the same cycle.
- Ordering: strict first in, first out; no word is lost or duplicated across pointer wrap.

Optional Feature:
- Macro: SYNC_FIFO_FLUSH_EN.
- Defined:
  - Adds the flush input. flush==1 at an edge clears the pointers, ram_count and out_valid exactly like reset, but flush is a normal synchronous input and is overridden by reset.
  - flush has priority over any write or read transfer at the same edge; that transfer is discarded.
  - The flags follow the cleared level on the next cycle.
- Undefined: the flush port does not exist, and the FIFO contents are cleared only by reset.

Test Plan:
1. Hold reset=0 for 2 cycles, then release -> in_ready=1, out_valid=0, level=0, out_almost_empty=1, in_almost_full=0.
2. WIDTH=8: write 0xA5 in cycle 0 with out_ready=1 -> out_valid=1 and out_data=0xA5 in cycle 2; level=1 during cycle 2, 0 in cycle 3.
3. DEPTH=8, ALMOST_FULL_LEVEL=7, out_ready=0, write 0x00..0x0F continuously:
   - exactly 9 words accepted (0x00..0x08), then in_ready=0 and level=9;
   - in_almost_full=1 from the cycle level reaches 7.
4. From the full state of scenario 3: pulse out_ready for 1 cycle with in_valid=1 -> 0x00 consumed, no write that cycle; in_ready=1 next cycle; 0x09 accepted; drained order is 0x01..0x09.
5. DEPTH=8: stream 3*DEPTH+5 incrementing words with pseudo-random in_valid and out_ready -> output sequence is identical to input, and level never exceeds 9.
6. With level=5, drive reset=0 for 1 cycle (repeat with flush=1 when SYNC_FIFO_FLUSH_EN is defined) -> level=0 and out_valid=0 next cycle; a following write of 0x3C is the first word out.
